apu_sequencer: RTL and testbench

APU_SEQUENCER -- requirements
Module: apu_sequencer

---
 rtl/apu_sequencer.sv | 170 +++++++++++++++++
 tb/tb_apu_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_sequencer.sv
// Tracker-style pattern sequencer: walks ROWS x 4 channels of a pattern ROM,
// one row every TICKS_PER_ROW frame pulses, and issues channel register writes to the APU.
module apu_sequencer #(
    parameter  int ROWS          = 64,
    parameter  int TICKS_PER_ROW = 6,
    localparam int RW            = $clog2(ROWS),
    localparam int TW            = $clog2(TICKS_PER_ROW + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_enable,
    input  logic          i_frame_pulse,
    output logic          o_rom_en,
    output logic [RW+1:0] o_rom_addr,
    input  logic [15:0]   i_rom_data,
    output logic          o_wr_valid,
    input  logic          i_wr_ready,
    output logic [1:0]    o_wr_channel,
    output logic [6:0]    o_wr_note,
    output logic [3:0]    o_wr_volume,
    output logic [3:0]    o_wr_instr,
    output logic [RW-1:0] o_row,
    output logic          o_busy,
    output logic          o_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_FETCH,
        S_LATCH,
        S_WRITE
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [1:0]      ch_q, ch_d;
    logic            rom_en_q, rom_en_d;
    logic [RW+1:0]   rom_addr_q, rom_addr_d;
    logic            wr_valid_q, wr_valid_d;
    logic [1:0]      wr_channel_q, wr_channel_d;
    logic [6:0]      wr_note_q, wr_note_d;
    logic [3:0]      wr_volume_q, wr_volume_d;
    logic [3:0]      wr_instr_q, wr_instr_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic            advance;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        row_d        = row_q;
        tick_d       = tick_q;
        ch_d         = ch_q;
        rom_addr_d   = rom_addr_q;
        wr_valid_d   = wr_valid_q;
        wr_channel_d = wr_channel_q;
        wr_note_d    = wr_note_q;
        wr_volume_d  = wr_volume_q;
        wr_instr_d   = wr_instr_q;
        advance      = 1'b0;
        // A frame pulse during a row fetch is lost; remember that it happened.
        overrun_d    = overrun_q | (i_frame_pulse & busy_q);

        case (state_q)
            S_IDLE: begin
                if (i_enable) begin
                    row_d   = '0;
                    tick_d  = '0;
                    ch_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_WAIT_TICK: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                end else if (i_frame_pulse) begin
                    if (tick_q == TW'(TICKS_PER_ROW - 1)) begin
                        tick_d  = '0;
                        row_d   = row_q + 1'b1;
                        ch_d    = '0;
                        state_d = S_FETCH;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                if (i_rom_data[15]) begin
                    wr_valid_d   = 1'b1;
                    wr_channel_d = ch_q;
                    wr_note_d    = i_rom_data[14:8];
                    wr_volume_d  = i_rom_data[7:4];
                    wr_instr_d   = i_rom_data[3:0];
                    state_d      = S_WRITE;
                end else begin
                    advance = 1'b1;
                end
            end
            S_WRITE: begin
                if (i_wr_ready) begin
                    wr_valid_d = 1'b0;
                    advance    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A row always finishes all four channels; a dropped enable only takes effect at the row end.
        if (advance) begin
            if (ch_q != 2'd3) begin
                ch_d    = ch_q + 1'b1;
                state_d = S_FETCH;
            end else begin
                state_d = i_enable ? S_WAIT_TICK : S_IDLE;
            end
        end

        rom_en_d = (state_d == S_FETCH);
        if (rom_en_d) rom_addr_d = {row_d, ch_d};
        busy_d = (state_d == S_FETCH) || (state_d == S_LATCH) || (state_d == S_WRITE);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            tick_q       <= '0;
            ch_q         <= '0;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            wr_valid_q   <= 1'b0;
            wr_channel_q <= '0;
            wr_note_q    <= '0;
            wr_volume_q  <= '0;
            wr_instr_q   <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            tick_q       <= tick_d;
            ch_q         <= ch_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            wr_valid_q   <= wr_valid_d;
            wr_channel_q <= wr_channel_d;
            wr_note_q    <= wr_note_d;
            wr_volume_q  <= wr_volume_d;
            wr_instr_q   <= wr_instr_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_rom_en     = rom_en_q;
    assign o_rom_addr   = rom_addr_q;
    assign o_wr_valid   = wr_valid_q;
    assign o_wr_channel = wr_channel_q;
    assign o_wr_note    = wr_note_q;
    assign o_wr_volume  = wr_volume_q;
    assign o_wr_instr   = wr_instr_q;
    assign o_row        = row_q;
    assign o_busy       = busy_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_apu_sequencer.sv
// Directed bench for apu_sequencer with a 4-row pattern, 6 ticks per row,
// a registered ROM model and negedge monitors logging fetches and write transfers.
module tb_apu_sequencer;

    localparam int ROWS = 4;
    localparam int TPR  = 6;

    // {channel, note, volume, instrument} expected for row 0 and for row 2's two writes
    localparam logic [16:0] EXP_ROW0 [4] = '{
        {2'd0, 7'd10, 4'd5, 4'd1},
        {2'd1, 7'd20, 4'd6, 4'd2},
        {2'd2, 7'd30, 4'd7, 4'd3},
        {2'd3, 7'd40, 4'd8, 4'd4}
    };
    localparam logic [16:0] EXP_ROW1_CH1 = {2'd1, 7'd51, 4'd10, 4'd9};
    localparam logic [16:0] EXP_ROW2 [2] = '{
        {2'd0, 7'd60, 4'd3, 4'd7},
        {2'd2, 7'd61, 4'd4, 4'd8}
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        pulse = 1'b0;
    logic        ready = 1'b1;
    logic        rom_en;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic        wr_valid;
    logic [1:0]  wr_ch;
    logic [6:0]  wr_note;
    logic [3:0]  wr_vol;
    logic [3:0]  wr_ins;
    logic [1:0]  row;
    logic        busy;
    logic        overrun;

    logic [15:0] rom [16];
    int cyc = 0;
    int busy_cnt = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int         cyc;
        logic [1:0] ch;
        logic [6:0] note;
        logic [3:0] vol;
        logic [3:0] ins;
    } wr_t;
    typedef struct {
        int         cyc;
        logic [3:0] addr;
    } fe_t;
    wr_t wr_q[$];
    fe_t fe_q[$];

    apu_sequencer #(.ROWS(ROWS), .TICKS_PER_ROW(TPR)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (enable),
        .i_frame_pulse (pulse),
        .o_rom_en      (rom_en),
        .o_rom_addr    (rom_addr),
        .i_rom_data    (rom_data),
        .o_wr_valid    (wr_valid),
        .i_wr_ready    (ready),
        .o_wr_channel  (wr_ch),
        .o_wr_note     (wr_note),
        .o_wr_volume   (wr_vol),
        .o_wr_instr    (wr_ins),
        .o_row         (row),
        .o_busy        (busy),
        .o_overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data appears exactly one cycle after the strobe; zero otherwise so a mistimed capture reads note-off.
    always @(posedge clk) rom_data <= rom_en ? rom[rom_addr] : 16'h0000;

    always @(negedge clk) begin
        if (!rst) begin
            if (rom_en) fe_q.push_back('{cyc, rom_addr});
            if (wr_valid && ready) wr_q.push_back('{cyc, wr_ch, wr_note, wr_vol, wr_ins});
            if (busy) busy_cnt <= busy_cnt + 1;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pulse();
        pulse = 1'b1;
        step(1);
        pulse = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        step(3);
        total++; if (rom_en !== 1'b0) begin bad++; $display("FAIL reset_rom_en got=%0h exp=0", rom_en); end
        total++; if (rom_addr !== 4'd0) begin bad++; $display("FAIL reset_rom_addr got=%0h exp=0", rom_addr); end
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid got=%0h exp=0", wr_valid); end
        total++; if ({wr_ch, wr_note, wr_vol, wr_ins} !== 17'd0) begin bad++; $display("FAIL reset_wr_fields got=%0h exp=0", {wr_ch, wr_note, wr_vol, wr_ins}); end
        total++; if (row !== 2'd0) begin bad++; $display("FAIL reset_row got=%0h exp=0", row); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0h exp=0", overrun); end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_row0();
        int k, fb, wb, bc;
        fb = fe_q.size();
        wb = wr_q.size();
        bc = busy_cnt;
        enable = 1'b1;
        k = cyc;
        step(20);
        total++; if (fe_q.size() - fb !== 4) begin bad++; $display("FAIL row0_fetch_count got=%0d exp=4", fe_q.size() - fb); end
        if (fe_q.size() - fb == 4) begin
            for (int i = 0; i < 4; i++) begin
                total++; if (fe_q[fb+i].addr !== 4'(i)) begin bad++; $display("FAIL row0_fetch_addr%0d got=%0h exp=%0h", i, fe_q[fb+i].addr, i); end
                total++; if (fe_q[fb+i].cyc !== k + 1 + 3*i) begin bad++; $display("FAIL row0_fetch_cyc%0d got=%0d exp=%0d", i, fe_q[fb+i].cyc, k + 1 + 3*i); end
            end
        end
        total++; if (wr_q.size() - wb !== 4) begin bad++; $display("FAIL row0_write_count got=%0d exp=4", wr_q.size() - wb); end
        if (wr_q.size() - wb == 4) begin
            for (int i = 0; i < 4; i++) begin
                total++; if ({wr_q[wb+i].ch, wr_q[wb+i].note, wr_q[wb+i].vol, wr_q[wb+i].ins} !== EXP_ROW0[i]) begin
                    bad++; $display("FAIL row0_write%0d got=%0h exp=%0h", i, {wr_q[wb+i].ch, wr_q[wb+i].note, wr_q[wb+i].vol, wr_q[wb+i].ins}, EXP_ROW0[i]); end
                total++; if (wr_q[wb+i].cyc !== k + 3 + 3*i) begin bad++; $display("FAIL row0_write_cyc%0d got=%0d exp=%0d", i, wr_q[wb+i].cyc, k + 3 + 3*i); end
            end
        end
        total++; if (busy_cnt - bc !== 12) begin bad++; $display("FAIL row0_busy_cycles got=%0d exp=12", busy_cnt - bc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL row0_busy_after got=%0h exp=0", busy); end
        total++; if (row !== 2'd0) begin bad++; $display("FAIL row0_row got=%0h exp=0", row); end
    endtask

    task automatic test_ticks();
        int fb;
        fb = fe_q.size();
        repeat (TPR - 1) send_pulse();
        total++; if (fe_q.size() !== fb) begin bad++; $display("FAIL ticks_early_fetch got=%0d exp=%0d", fe_q.size(), fb); end
        total++; if (row !== 2'd0) begin bad++; $display("FAIL ticks_row_hold got=%0h exp=0", row); end
        pulse = 1'b1;
        step(1);
        pulse = 1'b0;
        total++; if (rom_en !== 1'b1) begin bad++; $display("FAIL ticks_fetch_en got=%0h exp=1", rom_en); end
        total++; if (rom_addr !== 4'd4) begin bad++; $display("FAIL ticks_fetch_addr got=%0h exp=4", rom_addr); end
        total++; if (row !== 2'd1) begin bad++; $display("FAIL ticks_row got=%0h exp=1", row); end
    endtask

    task automatic test_stall();
        int f, wb, n_ch1;
        f = cyc;
        wb = wr_q.size();
        step(5);
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid%0d got=%0h exp=1", i, wr_valid); end
            total++; if ({wr_ch, wr_note, wr_vol, wr_ins} !== EXP_ROW1_CH1) begin
                bad++; $display("FAIL stall_fields%0d got=%0h exp=%0h", i, {wr_ch, wr_note, wr_vol, wr_ins}, EXP_ROW1_CH1); end
            step(1);
        end
        ready = 1'b1;
        step(1);
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL stall_valid_drop got=%0h exp=0", wr_valid); end
        total++; if (rom_en !== 1'b1 || rom_addr !== 4'd6) begin bad++; $display("FAIL stall_ch2_fetch got=%0h/%0h exp=1/6", rom_en, rom_addr); end
        step(8);
        total++; if (wr_q.size() - wb !== 4) begin bad++; $display("FAIL stall_write_count got=%0d exp=4", wr_q.size() - wb); end
        n_ch1 = 0;
        for (int i = wb; i < wr_q.size(); i++) begin
            if (wr_q[i].ch == 2'd1) begin
                n_ch1++;
                total++; if (wr_q[i].cyc !== f + 15) begin bad++; $display("FAIL stall_xfer_cyc got=%0d exp=%0d", wr_q[i].cyc, f + 15); end
            end
        end
        total++; if (n_ch1 !== 1) begin bad++; $display("FAIL stall_ch1_transfers got=%0d exp=1", n_ch1); end
    endtask

    task automatic test_sparse();
        int fb, wb, bc;
        fb = fe_q.size();
        wb = wr_q.size();
        bc = busy_cnt;
        repeat (TPR) send_pulse();
        step(15);
        total++; if (fe_q.size() - fb !== 4) begin bad++; $display("FAIL sparse_fetch_count got=%0d exp=4", fe_q.size() - fb); end
        if (fe_q.size() - fb == 4) begin
            total++; if (fe_q[fb].addr !== 4'd8 || fe_q[fb+3].addr !== 4'd11) begin
                bad++; $display("FAIL sparse_fetch_addr got=%0h..%0h exp=8..b", fe_q[fb].addr, fe_q[fb+3].addr); end
        end
        total++; if (wr_q.size() - wb !== 2) begin bad++; $display("FAIL sparse_write_count got=%0d exp=2", wr_q.size() - wb); end
        if (wr_q.size() - wb == 2) begin
            for (int i = 0; i < 2; i++) begin
                total++; if ({wr_q[wb+i].ch, wr_q[wb+i].note, wr_q[wb+i].vol, wr_q[wb+i].ins} !== EXP_ROW2[i]) begin
                    bad++; $display("FAIL sparse_write%0d got=%0h exp=%0h", i, {wr_q[wb+i].ch, wr_q[wb+i].note, wr_q[wb+i].vol, wr_q[wb+i].ins}, EXP_ROW2[i]); end
            end
        end
        total++; if (busy_cnt - bc !== 10) begin bad++; $display("FAIL sparse_busy_cycles got=%0d exp=10", busy_cnt - bc); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL sparse_overrun got=%0h exp=0", overrun); end
    endtask

    task automatic test_wrap_overrun();
        int fb, bc;
        fb = fe_q.size();
        bc = busy_cnt;
        repeat (TPR) send_pulse();
        step(12);
        total++; if (row !== 2'd3) begin bad++; $display("FAIL wrap_row3 got=%0h exp=3", row); end
        total++; if (busy_cnt - bc !== 8) begin bad++; $display("FAIL wrap_row3_busy got=%0d exp=8", busy_cnt - bc); end
        total++; if (fe_q.size() - fb !== 4) begin bad++; $display("FAIL wrap_row3_fetches got=%0d exp=4", fe_q.size() - fb); end
        repeat (TPR - 1) send_pulse();
        pulse = 1'b1;
        step(1);
        pulse = 1'b0;
        total++; if (rom_en !== 1'b1 || rom_addr !== 4'd0) begin bad++; $display("FAIL wrap_addr got=%0h/%0h exp=1/0", rom_en, rom_addr); end
        total++; if (row !== 2'd0) begin bad++; $display("FAIL wrap_row got=%0h exp=0", row); end
        step(2);
        pulse = 1'b1;
        step(1);
        pulse = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%0h exp=1", overrun); end
        step(12);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_held got=%0h exp=1", overrun); end
        fb = fe_q.size();
        repeat (TPR - 1) send_pulse();
        total++; if (fe_q.size() !== fb) begin bad++; $display("FAIL overrun_tick_unchanged got=%0d exp=%0d", fe_q.size(), fb); end
        pulse = 1'b1;
        step(1);
        pulse = 1'b0;
        total++; if (rom_en !== 1'b1 || rom_addr !== 4'd4) begin bad++; $display("FAIL overrun_next_row got=%0h/%0h exp=1/4", rom_en, rom_addr); end
    endtask

    task automatic test_disable();
        int fb, wb;
        wb = wr_q.size();
        enable = 1'b0;
        step(16);
        total++; if (wr_q.size() - wb !== 4) begin bad++; $display("FAIL disable_row_completes got=%0d exp=4", wr_q.size() - wb); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL disable_busy got=%0h exp=0", busy); end
        total++; if (row !== 2'd1) begin bad++; $display("FAIL disable_row_held got=%0h exp=1", row); end
        fb = fe_q.size();
        repeat (TPR) send_pulse();
        total++; if (fe_q.size() !== fb) begin bad++; $display("FAIL disable_idle_fetch got=%0d exp=%0d", fe_q.size(), fb); end
        enable = 1'b1;
        step(1);
        total++; if (rom_en !== 1'b1 || rom_addr !== 4'd0) begin bad++; $display("FAIL disable_restart got=%0h/%0h exp=1/0", rom_en, rom_addr); end
        total++; if (row !== 2'd0) begin bad++; $display("FAIL disable_restart_row got=%0h exp=0", row); end
    endtask

    task automatic test_reset_mid_write();
        int t, wb;
        ready = 1'b0;
        t = 0;
        while (wr_valid !== 1'b1 && t < 10) begin
            step(1);
            t++;
        end
        total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL midrst_wait_valid got=%0h exp=1", wr_valid); end
        wb = wr_q.size();
        #2 rst = 1'b1;
        #1;
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL midrst_wr_valid got=%0h exp=0", wr_valid); end
        total++; if ({wr_ch, wr_note, wr_vol, wr_ins} !== 17'd0) begin bad++; $display("FAIL midrst_fields got=%0h exp=0", {wr_ch, wr_note, wr_vol, wr_ins}); end
        total++; if ({rom_en, rom_addr, row, busy, overrun} !== 9'd0) begin
            bad++; $display("FAIL midrst_others got=%0h exp=0", {rom_en, rom_addr, row, busy, overrun}); end
        step(2);
        ready = 1'b1;
        rst = 1'b0;
        total++; if (wr_q.size() !== wb) begin bad++; $display("FAIL midrst_no_transfer got=%0d exp=%0d", wr_q.size(), wb); end
        total++; if (busy !== 1'b0 || rom_en !== 1'b0) begin bad++; $display("FAIL midrst_first_idle got=%0h/%0h exp=0/0", busy, rom_en); end
        step(1);
        total++; if (rom_en !== 1'b1 || rom_addr !== 4'd0) begin bad++; $display("FAIL midrst_restart got=%0h/%0h exp=1/0", rom_en, rom_addr); end
        total++; if (row !== 2'd0) begin bad++; $display("FAIL midrst_restart_row got=%0h exp=0", row); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rom[i]     = {1'b1, 7'(10 * (i + 1)), 4'(i + 5), 4'(i + 1)};
            rom[4 + i] = {1'b1, 7'(50 + i), 4'(9 + i), 4'(8 + i)};
            rom[12 + i] = 16'h7ABC;
        end
        rom[8]  = {1'b1, 7'd60, 4'd3, 4'd7};
        rom[9]  = 16'h7FFF;
        rom[10] = {1'b1, 7'd61, 4'd4, 4'd8};
        rom[11] = 16'h0000;

        test_reset();
        test_row0();
        test_ticks();
        test_stall();
        test_sparse();
        test_wrap_overrun();
        test_disable();
        test_reset_mid_write();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
